i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter_if.sv | 23 ++
 rtl/i2s_transmitter.sv | 110 +++++++++++
 tb/tb_i2s_transmitter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - sample-pair handshake between a source and the I2S transmitter
interface i2s_transmitter_if #(
  parameter int DATA_WIDTH = 24
) ();
  logic [DATA_WIDTH-1:0] data_left;
  logic [DATA_WIDTH-1:0] data_right;
  logic                  valid;
  logic                  ready;

  modport master (
    output data_left,
    output data_right,
    output valid,
    input  ready
  );

  modport slave (
    input  data_left,
    input  data_right,
    input  valid,
    output ready
  );
endinterface

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S serializer with a one-pair holding register, clocked by bick
module i2s_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32
) (
  input  logic               bick,
  input  logic               reset,
  input  logic               start,
  i2s_transmitter_if.slave   smp,
  output logic               lrck,
  output logic               sdti,
  output logic               stop,
  output logic               underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int KW         = $clog2(FRAME_BITS);

  localparam logic [KW-1:0] K_LAST      = KW'(FRAME_BITS - 1);
  localparam logic [KW-1:0] SLOT_K      = KW'(SLOT_BITS);
  localparam logic [KW-1:0] LEFT_FIRST  = KW'(1);
  localparam logic [KW-1:0] LEFT_LAST   = KW'(DATA_WIDTH);
  localparam logic [KW-1:0] RIGHT_FIRST = KW'(SLOT_BITS + 1);
  localparam logic [KW-1:0] RIGHT_LAST  = KW'(SLOT_BITS + DATA_WIDTH);

  if (DATA_WIDTH + 1 > SLOT_BITS) begin : g_bad_params
    $error("i2s_transmitter: DATA_WIDTH+1 must not exceed SLOT_BITS");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state, state_n;
  logic [KW-1:0]         k, k_n;
  logic                  frame_start;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [DATA_WIDTH-1:0] shift_l, shift_r;

  always_ff @(posedge bick or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Leaving idle or wrapping past the last cycle both land on k=0.
  always_comb begin
    state_n     = ST_IDLE;
    k_n         = '0;
    frame_start = 1'b0;
    if (start) begin
      state_n = ST_RUN;
      if (state == ST_IDLE || k == K_LAST) begin
        frame_start = 1'b1;
      end else begin
        k_n = k + 1'b1;
      end
    end
  end

  always_ff @(posedge bick or negedge reset) begin
    if (!reset) begin
      k        <= '0;
      lrck     <= 1'b0;
      sdti     <= 1'b0;
      underrun <= 1'b0;
      shift_l  <= '0;
      shift_r  <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      ready_q  <= 1'b1;
    end else begin
      k        <= k_n;
      lrck     <= (k_n >= SLOT_K);
      underrun <= frame_start && ready_q;

      if (!start) begin
        shift_l <= '0;
        shift_r <= '0;
        sdti    <= 1'b0;
      end else if (frame_start) begin
        sdti    <= 1'b0;
        shift_l <= ready_q ? '0 : hold_l;
        shift_r <= ready_q ? '0 : hold_r;
      end else if (k_n >= LEFT_FIRST && k_n <= LEFT_LAST) begin
        sdti    <= shift_l[DATA_WIDTH-1];
        shift_l <= shift_l << 1;
      end else if (k_n >= RIGHT_FIRST && k_n <= RIGHT_LAST) begin
        sdti    <= shift_r[DATA_WIDTH-1];
        shift_r <= shift_r << 1;
      end else begin
        sdti <= 1'b0;
      end

      // A full holding register blocks handshakes, so a frame start never collides with a load.
      if (frame_start && !ready_q) begin
        ready_q <= 1'b1;
      end else if (smp.valid && ready_q) begin
        hold_l  <= smp.data_left;
        hold_r  <= smp.data_right;
        ready_q <= 1'b0;
      end
    end
  end

  assign smp.ready = ready_q;
  assign stop      = (k == K_LAST) && start;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - scoreboard bench for i2s_transmitter
module tb_i2s_transmitter;
  localparam int DW = 24;
  localparam int SB = 32;
  localparam int FL = 2 * SB;

  localparam logic [FL-1:0] EXP_LRCK = {{SB{1'b1}}, {SB{1'b0}}};
  localparam logic [FL-1:0] EXP_STOP = {1'b1, {(FL-1){1'b0}}};
  localparam logic [FL-1:0] EXP_UND0 = {{(FL-1){1'b0}}, 1'b1};

  logic bick = 1'b0;
  logic reset;
  logic start;
  logic lrck, sdti, stop, underrun;

  i2s_transmitter_if #(.DATA_WIDTH(DW)) smp_if ();

  i2s_transmitter #(.DATA_WIDTH(DW), .SLOT_BITS(SB)) dut (
    .bick     (bick),
    .reset    (reset),
    .start    (start),
    .smp      (smp_if),
    .lrck     (lrck),
    .sdti     (sdti),
    .stop     (stop),
    .underrun (underrun)
  );

  always #5 bick = ~bick;

  int checks   = 0;
  int failures = 0;

  logic [2*DW-1:0] sb_q[$];
  logic [FL-1:0]   f_sdti, f_lrck, f_stop, f_und, f_rdy;

  function automatic logic [FL-1:0] exp_frame(input logic [2*DW-1:0] pair);
    logic [FL-1:0] e;
    logic [DW-1:0] l, r;
    e = '0;
    l = pair[2*DW-1:DW];
    r = pair[DW-1:0];
    for (int k = 1; k <= DW; k++) begin
      e[k]      = l[DW-k];
      e[SB + k] = r[DW-k];
    end
    return e;
  endfunction

  function automatic logic [2*DW-1:0] pop_expected();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic capture_frame(input bit drop_valid);
    for (int k = 0; k < FL; k++) begin
      @(negedge bick);
      f_sdti[k] = sdti;
      f_lrck[k] = lrck;
      f_stop[k] = stop;
      f_und[k]  = underrun;
      f_rdy[k]  = smp_if.ready;
      if (drop_valid && k == 0) smp_if.valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    smp_if.valid = 1'b0;
    smp_if.data_left = '0;
    smp_if.data_right = '0;
    repeat (2) @(negedge bick);
    checks++; if (smp_if.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", smp_if.ready); end
    checks++; if (lrck !== 1'b0) begin failures++; $display("FAIL reset_lrck got=%b exp=0", lrck); end
    checks++; if (sdti !== 1'b0) begin failures++; $display("FAIL reset_sdti got=%b exp=0", sdti); end
    checks++; if ({stop, underrun} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {stop, underrun}); end
    reset = 1'b1;
    @(negedge bick);
  endtask

  task automatic test_first_frame();
    logic [FL-1:0] e;
    checks++; if (smp_if.ready !== 1'b1) begin failures++; $display("FAIL ff_ready_idle got=%b exp=1", smp_if.ready); end
    smp_if.data_left  = 24'hA5A5A5;
    smp_if.data_right = 24'h3C3C3C;
    smp_if.valid = 1'b1;
    start = 1'b1;
    sb_q.push_back({24'hA5A5A5, 24'h3C3C3C});
    capture_frame(1'b1);
    checks++; if (f_sdti !== '0) begin failures++; $display("FAIL ff_frame0_sdti got=%h exp=0", f_sdti); end
    checks++; if (f_und !== EXP_UND0) begin failures++; $display("FAIL ff_frame0_underrun got=%h exp=%h", f_und, EXP_UND0); end
    checks++; if (f_rdy[0] !== 1'b0) begin failures++; $display("FAIL ff_ready_after_accept got=%b exp=0", f_rdy[0]); end
    capture_frame(1'b0);
    e = exp_frame(pop_expected());
    checks++; if (f_sdti !== e) begin failures++; $display("FAIL ff_frame1_sdti got=%h exp=%h", f_sdti, e); end
    checks++; if (f_und !== '0) begin failures++; $display("FAIL ff_frame1_underrun got=%h exp=0", f_und); end
    checks++; if (f_lrck !== EXP_LRCK) begin failures++; $display("FAIL ff_lrck got=%h exp=%h", f_lrck, EXP_LRCK); end
    checks++; if (f_stop !== EXP_STOP) begin failures++; $display("FAIL ff_stop got=%h exp=%h", f_stop, EXP_STOP); end
    start = 1'b0;
    repeat (2) @(negedge bick);
  endtask

  task automatic test_msb_pattern();
    logic [DW-1:0] r;
    logic [FL-1:0] e;
    r = DW'($urandom);
    smp_if.data_left  = 24'h800001;
    smp_if.data_right = r;
    smp_if.valid = 1'b1;
    start = 1'b1;
    sb_q.push_back({24'h800001, r});
    capture_frame(1'b1);
    capture_frame(1'b0);
    e = exp_frame(pop_expected());
    checks++; if (f_sdti !== e) begin failures++; $display("FAIL msb_frame_sdti got=%h exp=%h", f_sdti, e); end
    checks++; if ({f_sdti[24], f_sdti[1]} !== 2'b11) begin failures++; $display("FAIL msb_k1_k24 got=%b exp=11", {f_sdti[24], f_sdti[1]}); end
    checks++; if (f_sdti[23:2] !== '0) begin failures++; $display("FAIL msb_k2_23 got=%h exp=0", f_sdti[23:2]); end
    checks++; if ({f_sdti[31:25], f_sdti[0]} !== 8'h00) begin failures++; $display("FAIL msb_tail_k0 got=%h exp=00", {f_sdti[31:25], f_sdti[0]}); end
    start = 1'b0;
    repeat (2) @(negedge bick);
  endtask

  task automatic test_back_to_back();
    bit acc_prev;
    int acc_cnt;
    int acc_k;
    logic [FL-1:0] e;
    smp_if.data_left  = DW'($urandom);
    smp_if.data_right = DW'($urandom);
    smp_if.valid = 1'b1;
    start = 1'b1;
    acc_prev = smp_if.ready;
    if (smp_if.ready) sb_q.push_back({smp_if.data_left, smp_if.data_right});
    for (int f = 0; f < 4; f++) begin
      acc_cnt = 0;
      acc_k = -1;
      for (int k = 0; k < FL; k++) begin
        @(negedge bick);
        if (acc_prev) begin
          smp_if.data_left  = DW'($urandom);
          smp_if.data_right = DW'($urandom);
        end
        f_sdti[k] = sdti;
        f_lrck[k] = lrck;
        f_stop[k] = stop;
        f_und[k]  = underrun;
        acc_prev = smp_if.ready;
        if (smp_if.ready) begin
          sb_q.push_back({smp_if.data_left, smp_if.data_right});
          acc_cnt++;
          acc_k = k;
        end
      end
      e = (f == 0) ? '0 : exp_frame(pop_expected());
      checks++; if (f_sdti !== e) begin failures++; $display("FAIL b2b_sdti frame=%0d got=%h exp=%h", f, f_sdti, e); end
      checks++; if (f_und !== ((f == 0) ? EXP_UND0 : '0)) begin failures++; $display("FAIL b2b_underrun frame=%0d got=%h", f, f_und); end
      checks++; if (f_lrck !== EXP_LRCK || f_stop !== EXP_STOP) begin failures++; $display("FAIL b2b_lrck_stop frame=%0d lrck=%h stop=%h", f, f_lrck, f_stop); end
      checks++; if (acc_cnt !== ((f == 0) ? 0 : 1)) begin failures++; $display("FAIL b2b_accepts frame=%0d got=%0d", f, acc_cnt); end
      if (f > 0) begin
        checks++; if (acc_k !== 0) begin failures++; $display("FAIL b2b_accept_k frame=%0d got=%0d exp=0", f, acc_k); end
      end
    end
    smp_if.valid = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge bick);
  endtask

  task automatic test_restart();
    logic [FL-1:0] e;
    bit bad;
    start = 1'b1;
    capture_frame(1'b0);
    e = exp_frame(pop_expected());
    checks++; if (f_sdti !== e) begin failures++; $display("FAIL rs_held_frame got=%h exp=%h", f_sdti, e); end
    checks++; if (f_und !== '0) begin failures++; $display("FAIL rs_held_underrun got=%h exp=0", f_und); end
    for (int k = 0; k <= 40; k++) begin
      @(negedge bick);
      if (k == 0) begin
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL rs_empty_underrun got=%b exp=1", underrun); end
      end
      if (k == 5) begin
        smp_if.data_left  = DW'($urandom);
        smp_if.data_right = DW'($urandom);
        smp_if.valid = 1'b1;
        checks++; if (smp_if.ready !== 1'b1) begin failures++; $display("FAIL rs_ready_k5 got=%b exp=1", smp_if.ready); end
        sb_q.push_back({smp_if.data_left, smp_if.data_right});
      end
      if (k == 6) smp_if.valid = 1'b0;
    end
    start = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge bick);
      if ({lrck, sdti, stop, underrun} !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL rs_idle_outputs got=nonzero exp=0"); end
    checks++; if (smp_if.ready !== 1'b0) begin failures++; $display("FAIL rs_hold_kept ready=%b exp=0", smp_if.ready); end
    start = 1'b1;
    capture_frame(1'b0);
    e = exp_frame(pop_expected());
    checks++; if (f_sdti !== e) begin failures++; $display("FAIL rs_restart_frame got=%h exp=%h", f_sdti, e); end
    checks++; if (f_und !== '0 || f_lrck !== EXP_LRCK) begin failures++; $display("FAIL rs_restart_und_lrck und=%h lrck=%h", f_und, f_lrck); end
    start = 1'b0;
    repeat (2) @(negedge bick);
  endtask

  task automatic test_reset_mid();
    smp_if.data_left  = 24'hFFFFFF;
    smp_if.data_right = 24'hFFFFFF;
    smp_if.valid = 1'b1;
    start = 1'b1;
    capture_frame(1'b1);
    for (int k = 0; k <= 10; k++) begin
      @(negedge bick);
      if (k == 2) begin
        smp_if.data_left  = DW'($urandom);
        smp_if.data_right = DW'($urandom);
        smp_if.valid = 1'b1;
      end
      if (k == 3) smp_if.valid = 1'b0;
    end
    checks++; if ({sdti, smp_if.ready} !== 2'b10) begin failures++; $display("FAIL rm_before got=%b exp=10", {sdti, smp_if.ready}); end
    reset = 1'b0;
    #1;
    checks++; if ({lrck, sdti, stop, underrun} !== 4'b0000) begin failures++; $display("FAIL rm_outputs got=%b exp=0000", {lrck, sdti, stop, underrun}); end
    checks++; if (smp_if.ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", smp_if.ready); end
    sb_q.delete();
    @(negedge bick);
    reset = 1'b1;
    capture_frame(1'b0);
    checks++; if (f_und !== EXP_UND0 || f_sdti !== '0) begin failures++; $display("FAIL rm_after_frame und=%h sdti=%h", f_und, f_sdti); end
    checks++; if (f_stop !== EXP_STOP) begin failures++; $display("FAIL rm_after_stop got=%h exp=%h", f_stop, EXP_STOP); end
    start = 1'b0;
    repeat (2) @(negedge bick);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_msb_pattern();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
